// File: rtl/ccu_axil_initiator.sv
// AXI4-Lite master issuing single-beat writes, reads and poll-until-match reads, one response per command.
// Optional macro CCU_AXIL_POLL_TIMEOUT_EN bounds each POLL to POLL_LIMIT reads and reports rsp_timeout.
module ccu_axil_initiator #(
    parameter int ADDR_WIDTH = 8,
    parameter int POLL_GAP   = 4,
    parameter int POLL_LIMIT = 1024,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    input  logic [3:0]            cmd_wstrb,
    input  logic [31:0]           cmd_mask,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [CNT_WIDTH-1:0]  rsp_count,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [31:0]           m_axil_wdata,
    output logic [3:0]            m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [31:0]           m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, GAP, RSP} state_t;

    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [31:0]             wdata_reg, mask_reg, rdata_reg;
    logic [3:0]              wstrb_reg;
    logic [1:0]              resp_reg;
    logic [CNT_WIDTH-1:0]    count_reg;
    logic [GW-1:0]           gap_cnt_reg;
    logic                    poll_reg, aw_done_reg, w_done_reg;
    logic                    accept, aw_ok, w_ok, match, poll_done, limit_hit;

    assign accept    = cmd_valid && cmd_ready;
    assign aw_ok     = aw_done_reg || (m_axil_awvalid && m_axil_awready);
    assign w_ok      = w_done_reg || (m_axil_wvalid && m_axil_wready);
    assign match     = ((m_axil_rdata ^ wdata_reg) & mask_reg) == 32'h0;
    // An error response ends a poll just like a match does.
    assign poll_done = match || (m_axil_rresp != 2'b00) || limit_hit;

`ifdef CCU_AXIL_POLL_TIMEOUT_EN
    localparam int PW = $clog2(POLL_LIMIT + 1);
    logic [PW-1:0] poll_cnt_reg;
    logic          timeout_reg;

    assign limit_hit   = poll_cnt_reg >= PW'(POLL_LIMIT);
    assign rsp_timeout = timeout_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            poll_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else if (accept) begin
            poll_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else if (state_reg == RD_REQ && m_axil_arready) begin
            poll_cnt_reg <= poll_cnt_reg + 1'b1;
        end else if (state_reg == RD_DATA && m_axil_rvalid) begin
            // Only judged on the R handshake, so no open transaction is ever abandoned.
            timeout_reg <= poll_reg && !match && (m_axil_rresp == 2'b00) && limit_hit;
        end
    end
`else
    assign limit_hit   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = (cmd_op == 2'b00) ? WR_REQ : RD_REQ;
            WR_REQ:  if (aw_ok && w_ok) state_next = WR_RESP;
            WR_RESP: if (m_axil_bvalid) state_next = RSP;
            RD_REQ:  if (m_axil_arready) state_next = RD_DATA;
            RD_DATA: begin
                if (m_axil_rvalid) begin
                    if (!poll_reg || poll_done) state_next = RSP;
                    else if (POLL_GAP == 0)     state_next = RD_REQ;
                    else                        state_next = GAP;
                end
            end
            GAP:     if (gap_cnt_reg == GAP_LAST) state_next = RD_REQ;
            RSP:     if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready      = (state_reg == IDLE) && !rst;
        m_axil_awvalid = (state_reg == WR_REQ) && !aw_done_reg;
        m_axil_wvalid  = (state_reg == WR_REQ) && !w_done_reg;
        m_axil_bready  = (state_reg == WR_RESP);
        m_axil_arvalid = (state_reg == RD_REQ);
        m_axil_rready  = (state_reg == RD_DATA);
        rsp_valid      = (state_reg == RSP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            mask_reg    <= '0;
            poll_reg    <= 1'b0;
            rdata_reg   <= '0;
            resp_reg    <= '0;
            count_reg   <= '0;
            gap_cnt_reg <= '0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        addr_reg    <= cmd_addr;
                        wdata_reg   <= cmd_wdata;
                        wstrb_reg   <= cmd_wstrb;
                        mask_reg    <= cmd_mask;
                        poll_reg    <= (cmd_op == 2'b10);
                        rdata_reg   <= '0;
                        resp_reg    <= '0;
                        count_reg   <= '0;
                        aw_done_reg <= 1'b0;
                        w_done_reg  <= 1'b0;
                    end
                end
                WR_REQ: begin
                    if (m_axil_awvalid && m_axil_awready) aw_done_reg <= 1'b1;
                    if (m_axil_wvalid && m_axil_wready)   w_done_reg  <= 1'b1;
                end
                WR_RESP: if (m_axil_bvalid) resp_reg <= m_axil_bresp;
                RD_REQ: begin
                    if (m_axil_arready && count_reg != {CNT_WIDTH{1'b1}})
                        count_reg <= count_reg + 1'b1;
                end
                RD_DATA: begin
                    gap_cnt_reg <= '0;
                    if (m_axil_rvalid) begin
                        rdata_reg <= m_axil_rdata;
                        resp_reg  <= m_axil_rresp;
                    end
                end
                GAP:     gap_cnt_reg <= gap_cnt_reg + 1'b1;
                default: ;
            endcase
        end
    end

    assign rsp_rdata     = rdata_reg;
    assign rsp_resp      = resp_reg;
    assign rsp_count     = count_reg;
    assign m_axil_awaddr = addr_reg;
    assign m_axil_araddr = addr_reg;
    assign m_axil_wdata  = wdata_reg;
    assign m_axil_wstrb  = wstrb_reg;
    assign m_axil_awprot = 3'b000;
    assign m_axil_arprot = 3'b000;
endmodule

// File: tb/tb_ccu_axil_initiator.sv
// Directed bench for ccu_axil_initiator: AXI-Lite slave model with programmable stalls/errors and a response scoreboard.
`timescale 1ns/1ps
module tb_ccu_axil_initiator;
    localparam int AW  = 8;
    localparam int GAP = 4;
    localparam int CW  = 3;
`ifdef CCU_AXIL_POLL_TIMEOUT_EN
    localparam bit TMO = 1'b1;
    localparam int LIM = 4;
`else
    localparam bit TMO = 1'b0;
    localparam int LIM = 1 << 30;
`endif

    logic clk, rst;
    logic cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_timeout;
    logic [1:0] cmd_op, rsp_resp;
    logic [AW-1:0] cmd_addr, awaddr, araddr;
    logic [31:0] cmd_wdata, cmd_mask, rsp_rdata, wdata, rdata;
    logic [3:0] cmd_wstrb, wstrb;
    logic [CW-1:0] rsp_count;
    logic [2:0] awprot, arprot;
    logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [1:0] bresp, rresp;

    ccu_axil_initiator #(.ADDR_WIDTH(AW), .POLL_GAP(GAP), .POLL_LIMIT(4), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .rsp_count(rsp_count), .rsp_timeout(rsp_timeout),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
        .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
        .m_axil_araddr(araddr), .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid), .m_axil_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- slave model ----------------
    logic [31:0] mem [0:63];
    int aw_delay = 0, w_delay = 0, r_delay = 0;
    logic [1:0] bresp_val = 2'b00, rresp_val = 2'b00;
    int aw_wait, w_wait, r_wait;
    logic got_aw, got_w, ar_pend;
    logic [AW-1:0] aw_addr_q;
    logic [31:0] w_data_q, r_data_q, tmp;
    logic [3:0] w_strb_q;
    int ar_total = 0;
    int set_at = 0;

    assign awready = awvalid && !got_aw && (aw_wait >= aw_delay);
    assign wready  = wvalid && !got_w && (w_wait >= w_delay);
    assign bvalid  = got_aw && got_w;
    assign bresp   = bvalid ? bresp_val : 2'b00;
    assign arready = arvalid && !ar_pend;
    assign rvalid  = ar_pend && (r_wait >= r_delay);
    assign rdata   = rvalid ? r_data_q : 32'h0;
    assign rresp   = rvalid ? rresp_val : 2'b00;

    always @(posedge clk) begin
        if (rst) begin
            got_aw <= 1'b0; got_w <= 1'b0; ar_pend <= 1'b0;
            aw_wait <= 0; w_wait <= 0; r_wait <= 0;
        end else begin
            if (awvalid && !got_aw) begin
                if (awready) begin got_aw <= 1'b1; aw_addr_q <= awaddr; aw_wait <= 0; end
                else aw_wait <= aw_wait + 1;
            end
            if (wvalid && !got_w) begin
                if (wready) begin got_w <= 1'b1; w_data_q <= wdata; w_strb_q <= wstrb; w_wait <= 0; end
                else w_wait <= w_wait + 1;
            end
            if (bvalid && bready) begin
                got_aw <= 1'b0; got_w <= 1'b0;
                for (int b = 0; b < 4; b++)
                    if (w_strb_q[b]) mem[aw_addr_q[7:2]][8*b +: 8] <= w_data_q[8*b +: 8];
            end
            if (arvalid && arready) begin
                tmp = mem[araddr[7:2]];
                if (ar_total + 1 == set_at) begin
                    tmp = tmp | 32'h1;
                    mem[araddr[7:2]] <= tmp;
                end
                r_data_q <= tmp;
                ar_total <= ar_total + 1;
                ar_pend  <= 1'b1;
                r_wait   <= 0;
            end else if (ar_pend && !rvalid) begin
                r_wait <= r_wait + 1;
            end
            if (rvalid && rready) ar_pend <= 1'b0;
        end
    end

    // ---------------- protocol monitor ----------------
    int aw_hs = 0, w_hs = 0, ar_hs = 0, rsp_rises = 0, stab_err = 0, drop_err = 0;
    int acc_cyc = 0, aw_cyc = -10, w_cyc = -10, b_cyc = 0, ar_cyc = 0, r_cyc = 0, rsp_cyc = 0;
    int last_r_cyc = -1, min_gap = 1000;
    logic aw_pend_m = 0, w_pend_m = 0, ar_pend_m = 0, rsp_prev = 0;
    logic [AW-1:0] aw_hold, ar_hold;
    logic [31:0] w_hold;

    always @(negedge clk) begin
        if (rst) begin
            aw_pend_m = 0; w_pend_m = 0; ar_pend_m = 0;
        end else begin
            if (aw_pend_m && !(awvalid && awaddr == aw_hold)) stab_err++;
            if (w_pend_m && !(wvalid && wdata == w_hold)) stab_err++;
            if (ar_pend_m && !(arvalid && araddr == ar_hold)) stab_err++;
            if (awvalid && cyc == aw_cyc + 1) drop_err++;
            if (wvalid && cyc == w_cyc + 1) drop_err++;
            aw_pend_m = awvalid && !awready; aw_hold = awaddr;
            w_pend_m  = wvalid && !wready;   w_hold  = wdata;
            ar_pend_m = arvalid && !arready; ar_hold = araddr;
            if (cmd_valid && cmd_ready) acc_cyc = cyc;
            if (awvalid && awready) begin aw_hs++; aw_cyc = cyc; end
            if (wvalid && wready) begin w_hs++; w_cyc = cyc; end
            if (bvalid && bready) b_cyc = cyc;
            if (arvalid && arready) begin
                ar_hs++; ar_cyc = cyc;
                if (last_r_cyc >= 0 && cyc - last_r_cyc - 1 < min_gap) min_gap = cyc - last_r_cyc - 1;
            end
            if (rvalid && rready) begin r_cyc = cyc; last_r_cyc = cyc; end
            if (rsp_valid && !rsp_prev) begin rsp_rises++; rsp_cyc = cyc; end
        end
        rsp_prev = rsp_valid;
    end

    // ---------------- checking ----------------
    int vectors = 0, miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic [31:0] count;
        logic        tmo;
    } exp_t;
    exp_t sb[$];

    task automatic push(input string tag, input logic [31:0] d, input logic [1:0] r, input int c, input logic t);
        exp_t e;
        e.tag = tag; e.rdata = d; e.resp = r; e.count = c; e.tmo = t;
        sb.push_back(e);
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] m);
        int n = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_mask = m;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        chk("cmd_accepted", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        $display("cmd op=%0d addr=0x%02h data=0x%08h strb=%h mask=0x%08h", op, a, d, s, m);
    endtask

    task automatic get_rsp();
        int n = 0;
        exp_t e;
        @(negedge clk);
        while (!rsp_valid && n < 2000) begin @(negedge clk); n++; end
        chk("rsp_arrived", rsp_valid, 1);
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, ".rdata"}, rsp_rdata, e.rdata);
            chk({e.tag, ".resp"}, rsp_resp, e.resp);
            chk({e.tag, ".count"}, rsp_count, e.count);
            chk({e.tag, ".timeout"}, rsp_timeout, e.tmo);
            chk({e.tag, ".cmd_ready_busy"}, cmd_ready, 0);
            $display("rsp %s rdata=0x%08h resp=%0d count=%0d timeout=%0d", e.tag, rsp_rdata, rsp_resp, rsp_count, rsp_timeout);
        end
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_rsp", cmd_ready, 1);
    endtask

    task automatic do_reset(input int cycles);
        @(posedge clk); #1; rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1; rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    int ar0, aw0, w0, rise0, stall_err, n;
    logic [31:0] hold_d;

    initial begin
        rst = 1'b1; cmd_valid = 0; cmd_op = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; cmd_mask = 0;
        rsp_ready = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[5]  = 32'h1122_3344;
        mem[9]  = 32'hDEAD_BEEF;
        mem[12] = 32'h0000_0100;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset.cmd_ready", cmd_ready, 0);
        chk("reset.valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("post_reset.cmd_ready", cmd_ready, 1);
        chk("post_reset.rsp", {rsp_valid, rsp_timeout, rsp_resp}, 0);
        chk("post_reset.rdata", rsp_rdata, 0);
        chk("post_reset.count", rsp_count, 0);

        // Write with awready delayed 3 cycles
        aw_delay = 3; aw0 = aw_hs; w0 = w_hs;
        push("wr_aw_delay", 32'h0, 2'b00, 0, 1'b0);
        do_cmd(2'b00, 8'h10, 32'h0000_0001, 4'hF, 32'h0);
        get_rsp();
        chk("wr_aw_delay.aw_hs", aw_hs - aw0, 1);
        chk("wr_aw_delay.w_hs", w_hs - w0, 1);
        chk("wr_aw_delay.drop", drop_err, 0);
        chk("wr_aw_delay.mem", mem[4], 32'h0000_0001);
        aw_delay = 0;

        // Zero-wait write latency
        push("wr_zero", 32'h0, 2'b00, 0, 1'b0);
        do_cmd(2'b00, 8'h28, 32'hCAFE_F00D, 4'hF, 32'h0);
        get_rsp();
        chk("wr_zero.aw_lat", aw_cyc - acc_cyc, 1);
        chk("wr_zero.b_lat", b_cyc - acc_cyc, 2);
        chk("wr_zero.rsp_lat", rsp_cyc - acc_cyc, 3);

        // Zero-wait read latency
        push("rd_zero", 32'hCAFE_F00D, 2'b00, 1, 1'b0);
        do_cmd(2'b01, 8'h28, 32'h0, 4'h0, 32'h0);
        get_rsp();
        chk("rd_zero.ar_lat", ar_cyc - acc_cyc, 1);
        chk("rd_zero.r_lat", r_cyc - acc_cyc, 2);
        chk("rd_zero.rsp_lat", rsp_cyc - acc_cyc, 3);

        // Read with rvalid delayed 2 cycles
        r_delay = 2;
        push("rd_delay", 32'hDEAD_BEEF, 2'b00, 1, 1'b0);
        do_cmd(2'b01, 8'h24, 32'h0, 4'h0, 32'h0);
        get_rsp();
        chk("rd_delay.rsp_after_r", rsp_cyc - r_cyc, 1);
        r_delay = 0;

        // Partial strobes then read back
        push("wr_strb", 32'h0, 2'b00, 0, 1'b0);
        do_cmd(2'b00, 8'h14, 32'hAABB_CCDD, 4'b0011, 32'h0);
        get_rsp();
        chk("wr_strb.mem", mem[5], 32'h1122_CCDD);
        push("rd_strb", 32'h1122_CCDD, 2'b00, 1, 1'b0);
        do_cmd(2'b01, 8'h14, 32'h0, 4'h0, 32'h0);
        get_rsp();

        // Reserved op behaves as READ
        push("rd_op11", 32'hDEAD_BEEF, 2'b00, 1, 1'b0);
        do_cmd(2'b11, 8'h24, 32'h0, 4'h0, 32'h0);
        get_rsp();

        // Poll with mask 0 matches immediately
        push("poll_mask0", 32'hDEAD_BEEF, 2'b00, 1, 1'b0);
        do_cmd(2'b10, 8'h24, 32'h0000_FFFF, 4'h0, 32'h0);
        get_rsp();

        // Poll: bit0 appears on the 6th read
        set_at = ar_total + 6; ar0 = ar_hs; min_gap = 1000; last_r_cyc = -1;
        if (TMO && 6 > LIM) push("poll6", 32'h0000_0100, 2'b00, LIM, 1'b1);
        else                push("poll6", 32'h0000_0101, 2'b00, 6, 1'b0);
        do_cmd(2'b10, 8'h30, 32'h0000_0001, 4'h0, 32'h0000_0001);
        get_rsp();
        chk("poll6.ar_hs", ar_hs - ar0, (TMO && 6 > LIM) ? LIM : 6);
        chk("poll6.min_gap_ok", min_gap >= GAP, 1);
        set_at = 0;

        // Poll matching on 9th read: rsp_count saturates at 7
        set_at = ar_total + 9;
        if (TMO && 9 > LIM) push("poll_sat", 32'h0, 2'b00, LIM, 1'b1);
        else                push("poll_sat", 32'h1, 2'b00, 7, 1'b0);
        do_cmd(2'b10, 8'h34, 32'h0000_0001, 4'h0, 32'h0000_0001);
        get_rsp();
        set_at = 0;

        // Error responses
        bresp_val = 2'b10;
        push("wr_slverr", 32'h0, 2'b10, 0, 1'b0);
        do_cmd(2'b00, 8'h20, 32'h1234_5678, 4'hF, 32'h0);
        get_rsp();
        bresp_val = 2'b00;
        rresp_val = 2'b10;
        push("poll_slverr", 32'h0, 2'b10, 1, 1'b0);
        do_cmd(2'b10, 8'h38, 32'h0000_0001, 4'h0, 32'h0000_0001);
        get_rsp();
        rresp_val = 2'b00;

        // Response back-pressure; a command offered meanwhile must be ignored
        push("wr_stall", 32'h0, 2'b00, 0, 1'b0);
        do_cmd(2'b00, 8'h1C, 32'h5A5A_5A5A, 4'hF, 32'h0);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        hold_d = rsp_rdata; stall_err = 0; ar0 = ar_hs;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 8'h24;
        repeat (10) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== hold_d || rsp_resp !== 2'b00 || rsp_count !== 0) stall_err++;
            if (cmd_ready || awvalid || wvalid || arvalid || bready || rready) stall_err++;
        end
        @(posedge clk); #1; cmd_valid = 1'b0;
        chk("wr_stall.stable", stall_err, 0);
        chk("wr_stall.no_ar", ar_hs - ar0, 0);
        get_rsp();
        chk("wr_stall.mem", mem[7], 32'h5A5A_5A5A);

        // Reset in the middle of WR_REQ
        aw_delay = 6; w_delay = 6;
        do_cmd(2'b00, 8'h18, 32'hFFFF_FFFF, 4'hF, 32'h0);
        @(negedge clk);
        chk("rst_mid.pre_valid", {awvalid, wvalid}, 2'b11);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("rst_mid.valids", {awvalid, wvalid, arvalid, rsp_valid}, 0);
        chk("rst_mid.cmd_ready", cmd_ready, 1);
        chk("rst_mid.mem", mem[6], 32'h0);
        aw_delay = 0; w_delay = 0;

        // Poll that never matches
        ar0 = ar_hs; rise0 = rsp_rises;
        if (TMO) begin
            push("poll_never", 32'h0, 2'b00, LIM, 1'b1);
            do_cmd(2'b10, 8'h3C, 32'h1234_5678, 4'h0, 32'hFFFF_FFFF);
            get_rsp();
            chk("poll_never.ar_hs", ar_hs - ar0, LIM);
        end else begin
            do_cmd(2'b10, 8'h3C, 32'h1234_5678, 4'h0, 32'hFFFF_FFFF);
            n = 0;
            while (ar_hs - ar0 <= 100 && n < 3000) begin @(negedge clk); n++; end
            chk("poll_never.reads_gt_100", ar_hs - ar0 > 100, 1);
            chk("poll_never.no_rsp", rsp_rises - rise0, 0);
            do_reset(2);
            @(negedge clk);
            chk("poll_never.cmd_ready", cmd_ready, 1);
        end

        chk("axi.stability", stab_err, 0);
        chk("sb.drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
